// File: rtl/rf_pkg.sv
// Shared types for the register-file write-back buffer.
// Entry layout and pointer sizing used by the queue and its match logic.
package rf_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_age_match.sv
// Youngest-match lookup over the pending write-back queue.
// Walks oldest to youngest from the head so the last hit wins.
module wb_age_match
  import rf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  wb_entry_t              ent [DEPTH],
  input  logic [DEPTH-1:0]       vld,
  input  logic [PW-1:0]          head,
  input  logic [WB_ADDR_W-1:0]   addr,
  output logic                   hit,
  output logic [WB_DATA_W-1:0]   data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (vld[idx] && ent[idx].addr == addr) begin
        hit  = 1'b1;
        data = ent[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_writeback_buffer.sv
// In-order write-back queue in front of the register file, with read bypass.
// Define WB_BYPASS_EN to forward pending data; otherwise producers stall on hazards.
module rf_writeback_buffer
  import rf_pkg::*;
#(
  parameter  int DATA_W = WB_DATA_W,
  parameter  int ADDR_W = WB_ADDR_W,
  parameter  int DEPTH  = 4,
  localparam int PW     = ptr_w(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic              byp_hit1,
  output logic [DATA_W-1:0] byp_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data2,
  output logic [CW-1:0]     count
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic              push, pop;
  logic              nempty, full;
  logic              hit1, hit2;
  logic [DATA_W-1:0] mdata1, mdata2;

  wb_age_match #(.DEPTH(DEPTH)) u_match1 (
    .ent  (mem_q),
    .vld  (vld_q),
    .head (rd_q),
    .addr (rd_addr1),
    .hit  (hit1),
    .data (mdata1)
  );

  wb_age_match #(.DEPTH(DEPTH)) u_match2 (
    .ent  (mem_q),
    .vld  (vld_q),
    .head (rd_q),
    .addr (rd_addr2),
    .hit  (hit2),
    .data (mdata2)
  );

  always_comb begin
    nempty = (cnt_q != '0);
    full   = (cnt_q == CW'(DEPTH));
`ifdef WB_BYPASS_EN
    in_ready = ~full;
`else
    in_ready = ~full & ~hit1 & ~hit2;
`endif
    push     = in_valid & in_ready;
    pop      = nempty & ~rf_stall;
    rf_we    = pop;
    rf_waddr = nempty ? mem_q[rd_q].addr : '0;
    rf_wdata = nempty ? mem_q[rd_q].data : '0;
    count    = cnt_q;

    mem_d = mem_q;
    vld_d = vld_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;

    if (pop) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + PW'(1);
    end
    if (push) begin
      mem_d[wr_q] = '{addr: in_addr, data: in_data};
      vld_d[wr_q] = 1'b1;
      wr_d        = wr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    byp_hit1  = hit1;
    byp_data1 = mdata1;
    byp_hit2  = hit2;
    byp_data2 = mdata2;
  end
`else
  logic unused_mdata;
  assign unused_mdata = ^{mdata1, mdata2};

  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
